pipe_datapath_fwd: RTL and testbench
====================================

Name: pipe_datapath_fwd

Overview:
Parametrised successor of the team's 3-stage pipelined ALU datapath: 32-bit instruction in, register file, ALU result out. It adds configurable data width and register count, an instruction-valid/result-valid handshake, and EX-to-decode forwarding, so dependent instructions can issue back-to-back with no stalls. It also adds SUB/XOR opcodes, selectable immediate extension and a debug register-read port for the bench.

Parameters:
DATA_W, 32, datapath/register width; legal range 16..64.
REG_ADDR_W, 5, register index width; NUM_REGS = 2**REG_ADDR_W; legal range 1..5; only the low REG_ADDR_W bits of each 5-bit field are used.
SIGN_EXT_IMM, 0, 0 zero-extends imm16 to DATA_W; 1 sign-extends it.

Ports:
clk  input  1  clock; all state changes on the rising edge.
reset  input  1  asynchronous, active-high; clears all state.
InstIn  input  32  instruction word.
InstValid  input  1  InstIn is sampled only when this is 1.
ALUOut  output  DATA_W  registered ALU result of the retiring instruction.
ALUValid  output  1  ALUOut/ALUDest hold a retiring result this cycle.
ALUDest  output  REG_ADDR_W  destination register of the retiring result.
DbgAddr  input  REG_ADDR_W  debug read index.
DbgData  output  DATA_W  combinational regfile[DbgAddr]; reflects post-edge contents.

Behaviour:
- Encoding: [31:29] class (010 = R, 011 = I, other = NOP); [28:26] func; [25:21] rd; [20:16] rs; [15:11] rt (R); [15:0] imm (I).
- Operand B: regfile[rt] for R-type; extended imm for I-type.
- func: 001 NOT (~A, B ignored); 010 ADD (A+B); 011 SUB (A-B); 100 OR; 101 AND; 110 SLT (signed A<B gives 1, else 0); 111 XOR; 000 NOP.
- ADD/SUB are modulo 2**DATA_W; no carry or overflow output.
- Any NOP (unknown class, func 000, or InstValid=0) travels as a bubble: no regfile write, ALUValid=0 at retire.
- r0 is an ordinary writable register, not hardwired to zero.
- Pipeline: stage IR captures {InstIn, InstValid} at edge k. Decode reads the regfile combinationally and registers operands into ID/EX at edge k+1. EX computes the ALU result and writes ALUOut, ALUDest, ALUValid and regfile[rd] at edge k+2. Latency is 2 edges from capture; throughput is 1 instruction per cycle.
- Forwarding: if the EX instruction is valid and writing, and its rd equals the decode rs (or rt for R-type), decode takes the live ALU result instead of the regfile value.
  - An instruction two slots later reads the regfile, which was already written at the same edge. No stalls ever.
- If both rs and rt match the EX rd, both operands are forwarded.
- An I-type instruction never forwards on the rt field.
- Reset (async, any time): IR and ID/EX are invalidated; ALUOut=0, ALUValid=0, ALUDest=0; all NUM_REGS registers are 0.
  - In-flight writes are discarded.
  - First capture occurs at the first rising edge with reset low.
- A bubble in EX produces ALUValid=0, and ALUOut/ALUDest hold their previous values.

Test Plan:
- Reset then independent I-type instructions (DATA_W=32), one per cycle, each with rd=rs:
  - add r0,#5 gives 00000005.
  - add r1,#000A gives 0000000A.
  - add r2,#FFF8 gives 0000FFF8.
  - not r3 gives FFFFFFFF.
  - or r4,#AAAA gives 0000AAAA.
  - and r5,#FFFF gives 00000000.
  - slt r6,#FFF8 gives 00000001.
  - Each ALUOut/ALUValid=1 appears exactly 2 edges after its capture, and DbgData confirms every register.
- Back-to-back hazard chain after reset:
  - I add r1=r1+#5, then R add r2=r1+r1, then R add r3=r2+r1 gives 00000005, 0000000A, 0000000F.
  - No bubbles; second instruction exercises the rs+rt double forward, third exercises forward plus regfile read.
- SUB/XOR/SLT: r7=r0-r1 (5-10) gives FFFFFFFB; slt r8=r7<r0 gives 00000001; xor r9=r3^r4 gives FFFF5555.
- SIGN_EXT_IMM=1: add r2,#FFF8 from reset gives FFFFFFF8; with default 0 it gives 0000FFF8.
- Bubbles: InstValid=0, class 000 and func 000 each give ALUValid=0, no register change, and ALUOut holds its prior value.
- Reset mid-stream: assert reset asynchronously with two valid instructions in flight.
  - Outputs and all registers read 0 immediately; the in-flight writes never appear after release.
  - Repeat the parametrised run with DATA_W=16, REG_ADDR_W=3: rd field 01010 writes r2.

Source files
------------

// File: rtl/pipe_datapath_fwd.sv
// Three-stage pipelined ALU datapath (IR -> ID/EX -> EX/writeback) with a
// parametrised register file and EX-to-decode forwarding, so dependent
// instructions issue back-to-back without stalls.
module pipe_datapath_fwd #(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned REG_ADDR_W   = 5,
  parameter bit          SIGN_EXT_IMM = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           InstIn,
  input  logic                  InstValid,
  output logic [DATA_W-1:0]     ALUOut,
  output logic                  ALUValid,
  output logic [REG_ADDR_W-1:0] ALUDest,
  input  logic [REG_ADDR_W-1:0] DbgAddr,
  output logic [DATA_W-1:0]     DbgData
);

  localparam int unsigned NUM_REGS = 2 ** REG_ADDR_W;
  localparam int unsigned INST_W   = 32;
  localparam int unsigned IMM_W    = 16;

  localparam logic [2:0] CLS_R = 3'b010;
  localparam logic [2:0] CLS_I = 3'b011;

  localparam logic [2:0] F_NOP = 3'b000;
  localparam logic [2:0] F_NOT = 3'b001;
  localparam logic [2:0] F_ADD = 3'b010;
  localparam logic [2:0] F_SUB = 3'b011;
  localparam logic [2:0] F_OR  = 3'b100;
  localparam logic [2:0] F_AND = 3'b101;
  localparam logic [2:0] F_SLT = 3'b110;
  localparam logic [2:0] F_XOR = 3'b111;

  typedef struct packed {
    logic                  valid;
    logic [2:0]            func;
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     a;
    logic [DATA_W-1:0]     b;
  } idex_t;

  logic [INST_W-1:0]     ir_inst;
  logic                  ir_valid;
  idex_t                 ex;
  logic [DATA_W-1:0]     rf [NUM_REGS];

  logic [2:0]            id_cls;
  logic [2:0]            id_func;
  logic [REG_ADDR_W-1:0] id_rd;
  logic [REG_ADDR_W-1:0] id_rs;
  logic [REG_ADDR_W-1:0] id_rt;
  logic [IMM_W-1:0]      id_imm;
  logic                  id_is_r;
  logic                  id_valid;
  logic [DATA_W-1:0]     imm_ext;
  logic                  fwd_rs;
  logic                  fwd_rt;
  logic [DATA_W-1:0]     op_a;
  logic [DATA_W-1:0]     op_b;
  logic [DATA_W-1:0]     alu_res;
  logic                  unused_fields;

  // Instruction register; the word is only loaded when marked valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir_inst  <= '0;
      ir_valid <= 1'b0;
    end else begin
      ir_valid <= InstValid;
      if (InstValid) ir_inst <= InstIn;
    end
  end

  assign id_cls  = ir_inst[31:29];
  assign id_func = ir_inst[28:26];
  assign id_rd   = ir_inst[21 +: REG_ADDR_W];
  assign id_rs   = ir_inst[16 +: REG_ADDR_W];
  assign id_rt   = ir_inst[11 +: REG_ADDR_W];
  assign id_imm  = ir_inst[15:0];
  assign unused_fields = ^ir_inst[25:11];

  // Decode: classify, extend immediate, pick operands (forwarded from EX when it writes them).
  always_comb begin
    id_is_r  = (id_cls == CLS_R);
    id_valid = ir_valid && (id_is_r || (id_cls == CLS_I)) && (id_func != F_NOP);
    if (SIGN_EXT_IMM) imm_ext = DATA_W'($signed(id_imm));
    else              imm_ext = DATA_W'(id_imm);
    fwd_rs = ex.valid && (ex.rd == id_rs);
    fwd_rt = ex.valid && id_is_r && (ex.rd == id_rt);
    op_a   = fwd_rs ? alu_res : rf[id_rs];
    op_b   = imm_ext;
    if (id_is_r) op_b = fwd_rt ? alu_res : rf[id_rt];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex <= '0;
    end else begin
      ex <= '{valid: id_valid, func: id_func, rd: id_rd, a: op_a, b: op_b};
    end
  end

  always_comb begin
    alu_res = '0;
    case (ex.func)
      F_NOT:   alu_res = ~ex.a;
      F_ADD:   alu_res = ex.a + ex.b;
      F_SUB:   alu_res = ex.a - ex.b;
      F_OR:    alu_res = ex.a | ex.b;
      F_AND:   alu_res = ex.a & ex.b;
      F_SLT:   alu_res = DATA_W'($signed(ex.a) < $signed(ex.b));
      F_XOR:   alu_res = ex.a ^ ex.b;
      default: alu_res = '0;
    endcase
  end

  // Retire: bubbles drop ALUValid but leave ALUOut/ALUDest untouched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ALUOut   <= '0;
      ALUValid <= 1'b0;
      ALUDest  <= '0;
    end else begin
      ALUValid <= ex.valid;
      if (ex.valid) begin
        ALUOut  <= alu_res;
        ALUDest <= ex.rd;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) rf[i] <= '0;
    end else if (ex.valid) begin
      rf[ex.rd] <= alu_res;
    end
  end

  assign DbgData = rf[DbgAddr];

endmodule

// File: tb/tb_pipe_datapath_fwd.sv
// Randomised and directed bench for pipe_datapath_fwd: three configurations
// share one instruction stream and are checked against an in-order ISA model.
module tb_pipe_datapath_fwd;

  localparam int NI = 3;
  localparam int DW [NI] = '{32, 32, 16};
  localparam int AW [NI] = '{5, 5, 3};
  localparam bit SX [NI] = '{1'b0, 1'b1, 1'b0};

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] inst;
  logic        inst_valid;
  logic [4:0]  dbg_addr;

  logic [31:0] out0, out1, dd0, dd1;
  logic [15:0] out2, dd2;
  logic        v0, v1, v2;
  logic [4:0]  dest0, dest1;
  logic [2:0]  dest2;

  pipe_datapath_fwd #(.DATA_W(32), .REG_ADDR_W(5), .SIGN_EXT_IMM(1'b0)) u0 (
    .clk(clk), .reset(reset), .InstIn(inst), .InstValid(inst_valid),
    .ALUOut(out0), .ALUValid(v0), .ALUDest(dest0), .DbgAddr(dbg_addr), .DbgData(dd0));
  pipe_datapath_fwd #(.DATA_W(32), .REG_ADDR_W(5), .SIGN_EXT_IMM(1'b1)) u1 (
    .clk(clk), .reset(reset), .InstIn(inst), .InstValid(inst_valid),
    .ALUOut(out1), .ALUValid(v1), .ALUDest(dest1), .DbgAddr(dbg_addr), .DbgData(dd1));
  pipe_datapath_fwd #(.DATA_W(16), .REG_ADDR_W(3), .SIGN_EXT_IMM(1'b0)) u2 (
    .clk(clk), .reset(reset), .InstIn(inst), .InstValid(inst_valid),
    .ALUOut(out2), .ALUValid(v2), .ALUDest(dest2), .DbgAddr(dbg_addr[2:0]), .DbgData(dd2));

  always #5 clk = ~clk;

  logic [63:0] act_out [NI];
  logic [63:0] act_dd  [NI];
  logic [63:0] act_dest[NI];
  logic        act_v   [NI];
  assign act_out[0] = 64'(out0);  assign act_out[1] = 64'(out1);  assign act_out[2] = 64'(out2);
  assign act_dd[0]  = 64'(dd0);   assign act_dd[1]  = 64'(dd1);   assign act_dd[2]  = 64'(dd2);
  assign act_dest[0] = 64'(dest0); assign act_dest[1] = 64'(dest1); assign act_dest[2] = 64'(dest2);
  assign act_v[0] = v0; assign act_v[1] = v1; assign act_v[2] = v2;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- architectural model ----------------
  logic [63:0] arch [NI][32];
  logic [63:0] com  [NI][32];
  bit          pv   [NI][2];
  logic [63:0] pres [NI][2];
  int          prd  [NI][2];
  logic [63:0] e_out [NI];
  logic [63:0] e_dest[NI];
  bit          e_v   [NI];

  function automatic logic [63:0] wmask(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction

  function automatic longint sval(input logic [63:0] x, input int w);
    if (x[w-1]) return longint'(x) - (longint'(1) << w);
    return longint'(x);
  endfunction

  function automatic logic [63:0] alu(input int w, input logic [2:0] f,
                                      input logic [63:0] a, input logic [63:0] b);
    logic [63:0] m;
    m = wmask(w);
    case (f)
      3'd1: return ~a & m;
      3'd2: return (a + b) & m;
      3'd3: return (a - b) & m;
      3'd4: return a | b;
      3'd5: return a & b;
      3'd6: return (sval(a, w) < sval(b, w)) ? 64'd1 : 64'd0;
      3'd7: return a ^ b;
      default: return 64'd0;
    endcase
  endfunction

  task automatic flush_model();
    for (int i = 0; i < NI; i++) begin
      for (int r = 0; r < 32; r++) begin
        arch[i][r] = '0;
        com[i][r]  = '0;
      end
      for (int s = 0; s < 2; s++) begin
        pv[i][s] = 1'b0; pres[i][s] = '0; prd[i][s] = 0;
      end
      e_out[i] = '0; e_dest[i] = '0; e_v[i] = 1'b0;
    end
  endtask

  // Instructions execute in program order at capture; results retire two edges later.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      flush_model();
    end else begin
      for (int i = 0; i < NI; i++) begin
        logic [2:0]  cls, f;
        logic [63:0] a, b, res;
        int rd, rs, rt, am;
        bit ok;
        if (pv[i][1]) begin
          e_v[i] = 1'b1; e_out[i] = pres[i][1]; e_dest[i] = 64'(prd[i][1]);
          com[i][prd[i][1]] = pres[i][1];
        end else begin
          e_v[i] = 1'b0;
        end
        pv[i][1] = pv[i][0]; pres[i][1] = pres[i][0]; prd[i][1] = prd[i][0];
        cls = inst[31:29];
        f   = inst[28:26];
        am  = (1 << AW[i]) - 1;
        rd  = int'(inst[25:21]) & am;
        rs  = int'(inst[20:16]) & am;
        rt  = int'(inst[15:11]) & am;
        ok  = inst_valid && (cls == 3'b010 || cls == 3'b011) && (f != 3'd0);
        res = '0;
        if (ok) begin
          a = arch[i][rs];
          if (cls == 3'b010)  b = arch[i][rt];
          else if (SX[i])     b = 64'($signed(inst[15:0])) & wmask(DW[i]);
          else                b = 64'(inst[15:0]);
          res = alu(DW[i], f, a, b);
          arch[i][rd] = res;
        end
        pv[i][0] = ok; pres[i][0] = res; prd[i][0] = rd;
      end
    end
  end

  // Per-cycle comparison of every instance against the model.
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      int idx;
      idx = int'(dbg_addr) & ((1 << AW[i]) - 1);
      chk($sformatf("u%0d ALUValid", i), 64'(act_v[i]), 64'(e_v[i]));
      chk($sformatf("u%0d ALUOut", i), act_out[i], e_out[i]);
      chk($sformatf("u%0d ALUDest", i), act_dest[i], e_dest[i]);
      chk($sformatf("u%0d DbgData[%0d]", i, idx), act_dd[i], com[i][idx]);
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [31:0] ityp(input logic [2:0] f, input logic [4:0] rd,
                                       input logic [4:0] rs, input logic [15:0] imm);
    return {3'b011, f, rd, rs, imm};
  endfunction

  function automatic logic [31:0] rtyp(input logic [2:0] f, input logic [4:0] rd,
                                       input logic [4:0] rs, input logic [4:0] rt);
    return {3'b010, f, rd, rs, rt, 11'd0};
  endfunction

  task automatic issue(input logic [31:0] i, input logic v);
    inst = i; inst_valid = v;
    @(negedge clk); #1;
  endtask

  task automatic bubble();
    issue(32'h0, 1'b0);
  endtask

  task automatic align();
    @(negedge clk); #1;
  endtask

  task automatic dbg_chk(input string nm, input int inst_i, input logic [4:0] addr,
                         input logic [63:0] lit);
    dbg_addr = addr; #1;
    chk(nm, act_dd[inst_i], lit);
  endtask

  logic [31:0] dq_inst[$];
  logic [63:0] dq_lit[$];

  // Back-to-back issue; each u0 result must be visible exactly two edges after capture.
  task automatic run_dir();
    int n;
    n = dq_inst.size();
    for (int k = 0; k < n + 2; k++) begin
      if (k < n) issue(dq_inst[k], 1'b1);
      else       bubble();
      if (k >= 2) begin
        chk($sformatf("dir%0d valid", k - 2), 64'(v0), 64'd1);
        chk($sformatf("dir%0d out", k - 2), 64'(out0), dq_lit[k-2]);
      end else begin
        chk($sformatf("dir lead%0d valid", k), 64'(v0), 64'd0);
      end
    end
    dq_inst.delete();
    dq_lit.delete();
  endtask

  initial begin
    reset = 1'b1; inst = '0; inst_valid = 1'b0; dbg_addr = '0;
    flush_model();
    @(negedge clk); #1;
    chk("reset ALUOut", 64'(out0), 64'd0);
    chk("reset ALUValid", 64'(v0), 64'd0);
    chk("reset ALUDest", 64'(dest0), 64'd0);
    chk("reset r0", 64'(dd0), 64'd0);
    #1 reset = 1'b0;
    align();

    // Independent I-type ops, then SUB/SLT/XOR on their results.
    dq_inst = '{ityp(3'd2, 5'd0, 5'd0, 16'h0005), ityp(3'd2, 5'd1, 5'd1, 16'h000A),
                ityp(3'd2, 5'd2, 5'd2, 16'hFFF8), ityp(3'd1, 5'd3, 5'd3, 16'h0000),
                ityp(3'd4, 5'd4, 5'd4, 16'hAAAA), ityp(3'd5, 5'd5, 5'd5, 16'hFFFF),
                ityp(3'd6, 5'd6, 5'd6, 16'hFFF8), rtyp(3'd3, 5'd7, 5'd0, 5'd1),
                rtyp(3'd6, 5'd8, 5'd7, 5'd0),     rtyp(3'd7, 5'd9, 5'd3, 5'd4)};
    dq_lit  = '{64'h5, 64'hA, 64'hFFF8, 64'hFFFFFFFF, 64'hAAAA, 64'h0, 64'h1,
                64'hFFFFFFFB, 64'h1, 64'hFFFF5555};
    run_dir();
    dbg_chk("u0 r0", 0, 5'd0, 64'h5);
    dbg_chk("u0 r2", 0, 5'd2, 64'hFFF8);
    dbg_chk("u0 r3", 0, 5'd3, 64'hFFFFFFFF);
    dbg_chk("u0 r6", 0, 5'd6, 64'h1);
    dbg_chk("u0 r7", 0, 5'd7, 64'hFFFFFFFB);
    dbg_chk("u0 r9", 0, 5'd9, 64'hFFFF5555);
    dbg_chk("u1 r2 sext", 1, 5'd2, 64'hFFFFFFF8);
    dbg_chk("u1 r6 slt", 1, 5'd6, 64'h0);
    dbg_chk("u2 r2", 2, 5'd2, 64'hFFF8);
    align();

    // Hazard chain from reset: double forward, then forward plus regfile read.
    reset = 1'b1; #2 reset = 1'b0;
    align();
    dq_inst = '{ityp(3'd2, 5'd1, 5'd1, 16'h0005), rtyp(3'd2, 5'd2, 5'd1, 5'd1),
                rtyp(3'd2, 5'd3, 5'd2, 5'd1)};
    dq_lit  = '{64'h5, 64'hA, 64'hF};
    run_dir();
    dbg_chk("chain r1", 0, 5'd1, 64'h5);
    dbg_chk("chain r2", 0, 5'd2, 64'hA);
    dbg_chk("chain r3", 0, 5'd3, 64'hF);
    align();

    // Three kinds of bubble.
    issue(ityp(3'd2, 5'd4, 5'd4, 16'h0001), 1'b0);
    issue({3'b000, 3'b010, 5'd4, 5'd4, 16'h0001}, 1'b1);
    issue(ityp(3'd0, 5'd4, 5'd4, 16'h0001), 1'b1);
    bubble();
    bubble();
    chk("bubble valid", 64'(v0), 64'd0);
    chk("bubble hold out", 64'(out0), 64'hF);
    chk("bubble hold dest", 64'(dest0), 64'd3);
    dbg_chk("bubble r4", 0, 5'd4, 64'h0);
    align();

    // Asynchronous reset with two writes in flight.
    dbg_addr = 5'd3;
    issue(ityp(3'd2, 5'd5, 5'd5, 16'h0003), 1'b1);
    issue(ityp(3'd2, 5'd6, 5'd6, 16'h0004), 1'b1);
    reset = 1'b1; #1;
    chk("async rst out", 64'(out0), 64'd0);
    chk("async rst valid", 64'(v0), 64'd0);
    chk("async rst dest", 64'(dest0), 64'd0);
    chk("async rst r3", 64'(dd0), 64'd0);
    align();
    bubble();
    bubble();
    reset = 1'b0;
    bubble();
    bubble();
    bubble();
    chk("post rst valid", 64'(v0), 64'd0);
    dbg_chk("post rst r5", 0, 5'd5, 64'h0);
    dbg_chk("post rst r6", 0, 5'd6, 64'h0);
    align();

    // rd field 01010 lands in r10 at 5-bit index, r2 at 3-bit index.
    dq_inst = '{ityp(3'd2, 5'd10, 5'd10, 16'h0007)};
    dq_lit  = '{64'h7};
    run_dir();
    dbg_chk("u0 r10", 0, 5'd10, 64'h7);
    dbg_chk("u2 r2 via 01010", 2, 5'd2, 64'h7);
    dbg_chk("u0 r2 untouched", 0, 5'd2, 64'h0);
    align();

    // Random stream with frequent hazards and occasional async reset.
    for (int c = 0; c < 3000; c++) begin
      logic [2:0]  cls;
      logic [4:0]  rd, rs, rt;
      int          sel;
      dbg_addr = 5'($urandom);
      sel = $urandom_range(0, 9);
      if (sel < 4)      cls = 3'b010;
      else if (sel < 8) cls = 3'b011;
      else              cls = 3'($urandom);
      rd = $urandom_range(0, 1) ? 5'($urandom_range(0, 3)) : 5'($urandom);
      rs = $urandom_range(0, 1) ? 5'($urandom_range(0, 3)) : 5'($urandom);
      rt = $urandom_range(0, 1) ? 5'($urandom_range(0, 3)) : 5'($urandom);
      if ($urandom_range(0, 299) == 0) begin
        reset = 1'b1; #1 reset = 1'b0;
      end
      if (cls == 3'b010) issue({cls, 3'($urandom), rd, rs, rt, 11'($urandom)}, $urandom_range(0, 9) != 0);
      else               issue({cls, 3'($urandom), rd, rs, 16'($urandom)}, $urandom_range(0, 9) != 0);
    end

    for (int k = 0; k < 34; k++) begin
      dbg_addr = 5'(k);
      bubble();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
